// File: rtl/eth_pkg.sv
// ---------------------------------------------------------------------------
// eth_pkg -- shared definitions for the Ethernet/IPv4/UDP decapsulator.
//   * protocol constants (ethertype, IP version/IHL byte, UDP protocol number)
//   * header geometry on a 64-bit, 8-lane stream (byte n -> lane n%8, beat n/8)
//   * parser state enum
//   * helpers: tkeep ones-count, network-order byte swaps
// ---------------------------------------------------------------------------
package eth_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
    localparam logic [47:0] BCAST_MAC      = 48'hFF_FF_FF_FF_FF_FF;

    // 14 B Ethernet + 20 B IPv4 + 8 B UDP
    localparam int          HDR_BYTES      = 42;
    localparam logic [2:0]  HDR_LAST_BEAT  = 3'(HDR_BYTES / 8);
    localparam logic [3:0]  PAYLOAD_LANE   = 4'(HDR_BYTES % 8);

    // Beat that carries each checked / captured field
    localparam logic [2:0]  BEAT_DST_MAC   = 3'd0;
    localparam logic [2:0]  BEAT_ETYPE     = 3'd1;
    localparam logic [2:0]  BEAT_PROTO     = 3'd2;
    localparam logic [2:0]  BEAT_SADDR     = 3'd3;
    localparam logic [2:0]  BEAT_UDP       = 3'd4;

    typedef enum logic [1:0] {
        ST_HDR     = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_DROP    = 2'd3
    } state_t;

    // Number of valid lanes in a tkeep word
    function automatic logic [3:0] keep_count(input logic [7:0] keep);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, keep[i]};
        end
        return n;
    endfunction

    // Lane-ordered bytes (lower lane = earlier byte) to network-order value
    function automatic logic [15:0] be16(input logic [15:0] v);
        return {v[7:0], v[15:8]};
    endfunction

    function automatic logic [31:0] be32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

endpackage

// File: rtl/eth_realign.sv
// ---------------------------------------------------------------------------
// eth_realign -- 2-byte lane shifter for the UDP payload.
// The payload starts at lane 2 of the header's last beat; every output beat
// is {current lanes 0-1, held lanes 2-7}. A tail with more than two bytes
// needs one extra output beat, produced on flush_en from the hold register.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   hold_en               load hold register only (header's last beat)
//   push_en               emit shifted beat and reload hold register
//   flush_en              emit the held tail as the final beat
//   in_data/keep/last/user  input beat
//   m_tready              downstream ready
//   out_free              output register may take a new beat this cycle
//   m_tvalid/tdata/tkeep/tlast/tuser  registered output stream
// ---------------------------------------------------------------------------
module eth_realign
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold_en,
    input  logic        push_en,
    input  logic        flush_en,
    input  logic [63:0] in_data,
    input  logic [7:0]  in_keep,
    input  logic        in_last,
    input  logic        in_user,
    input  logic        m_tready,
    output logic        out_free,
    output logic        m_tvalid,
    output logic [63:0] m_tdata,
    output logic [7:0]  m_tkeep,
    output logic        m_tlast,
    output logic        m_tuser
);

    logic [47:0] held_data_r;
    logic [5:0]  held_keep_r;
    logic        held_user_r;
    logic        m_tvalid_r;
    logic [63:0] m_tdata_r;
    logic [7:0]  m_tkeep_r;
    logic        m_tlast_r;
    logic        m_tuser_r;
    logic        tail_merges_s;

    // A last beat of at most two bytes fits in the same output beat
    assign tail_merges_s = (keep_count(in_keep) <= PAYLOAD_LANE);
    assign out_free      = !m_tvalid_r || m_tready;

    // Hold register: upper six lanes of the most recent accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_data_r <= 48'h0;
            held_keep_r <= 6'h0;
            held_user_r <= 1'b0;
        end else if (hold_en || push_en) begin
            held_data_r <= in_data[63:16];
            held_keep_r <= in_keep[7:2];
            held_user_r <= in_user;
        end
    end

    // Output register: holds its beat steady until the consumer takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_tvalid_r <= 1'b0;
            m_tdata_r  <= 64'h0;
            m_tkeep_r  <= 8'h0;
            m_tlast_r  <= 1'b0;
            m_tuser_r  <= 1'b0;
        end else if (push_en) begin
            m_tvalid_r <= 1'b1;
            m_tdata_r  <= {in_data[15:0], held_data_r};
            m_tkeep_r  <= {in_keep[1:0], held_keep_r};
            m_tlast_r  <= in_last && tail_merges_s;
            m_tuser_r  <= in_last && tail_merges_s && in_user;
        end else if (flush_en) begin
            m_tvalid_r <= 1'b1;
            m_tdata_r  <= {16'h0, held_data_r};
            m_tkeep_r  <= {2'b00, held_keep_r};
            m_tlast_r  <= 1'b1;
            m_tuser_r  <= held_user_r;
        end else if (m_tready) begin
            m_tvalid_r <= 1'b0;
        end
    end

    assign m_tvalid = m_tvalid_r;
    assign m_tdata  = m_tdata_r;
    assign m_tkeep  = m_tkeep_r;
    assign m_tlast  = m_tlast_r;
    assign m_tuser  = m_tuser_r;

endmodule

// File: rtl/eth_decap.sv
// ---------------------------------------------------------------------------
// eth_decap -- strips Ethernet/IPv4/UDP headers from a 64-bit AXI-Stream
// frame and emits the UDP payload realigned to lane 0.
// Frames are kept only if dst MAC is MAC_ADDR or broadcast, ethertype is
// IPv4 with a 20-byte header, protocol is UDP and dport is UDP_DPORT.
// A frame ending inside the header with no payload byte is dropped. A frame
// whose header's last beat also ends the frame but carries payload lanes is
// accepted and its payload emitted as a single tail beat.
// Ports:
//   clk156, eth_rst_n       clock, async active-low reset
//   s_axis_*                received frames (tuser on last beat = good FCS)
//   m_axis_*                UDP payload stream
//   hdr_valid               one-cycle pulse per accepted header
//   eth_src, ip_saddr, ip_daddr, udp_sport, udp_len
//                           header fields, held until the next hdr_valid
//   rx_accept_cnt, rx_drop_cnt  frame tallies, only with ETH_DECAP_STATS_EN
// Build option: define ETH_DECAP_STATS_EN to add the frame counters.
// ---------------------------------------------------------------------------
module eth_decap
    import eth_pkg::*;
#(
    parameter logic [15:0] UDP_DPORT = 16'h3776,
    parameter logic [47:0] MAC_ADDR  = 48'h00_11_22_33_44_55
) (
    input  logic        clk156,
    input  logic        eth_rst_n,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic [63:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tkeep,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic        hdr_valid,
    output logic [47:0] eth_src,
    output logic [31:0] ip_saddr,
    output logic [31:0] ip_daddr,
    output logic [15:0] udp_sport,
`ifdef ETH_DECAP_STATS_EN
    output logic [31:0] rx_accept_cnt,
    output logic [31:0] rx_drop_cnt,
`endif
    output logic [15:0] udp_len
);

    state_t      state_r, state_s;
    logic [2:0]  cnt_r, cnt_s;
    logic        ready_en_r;
    logic        s_ready_s;
    logic        hs_s;
    logic        out_free_s;
    logic        beat_fail_s;
    logic        tail_has_payload_s;
    logic        hold_s, push_s, flush_s, hdr_pulse_s;

    logic [47:0] src_w_r;
    logic [31:0] saddr_w_r, daddr_w_r;
    logic [15:0] sport_w_r, ulen_w_r;
    logic        hdr_valid_r;
    logic [47:0] eth_src_r;
    logic [31:0] ip_saddr_r, ip_daddr_r;
    logic [15:0] udp_sport_r, udp_len_r;

    assign hs_s               = s_axis_tvalid && s_ready_s;
    assign tail_has_payload_s = (keep_count(s_axis_tkeep) > PAYLOAD_LANE);

    // Field check for whichever header beat is on the bus
    always_comb begin
        beat_fail_s = 1'b0;
        case (cnt_r)
            BEAT_DST_MAC: beat_fail_s = !(({be32(s_axis_tdata[31:0]), be16(s_axis_tdata[47:32])} == MAC_ADDR) ||
                                          ({be32(s_axis_tdata[31:0]), be16(s_axis_tdata[47:32])} == BCAST_MAC));
            BEAT_ETYPE:   beat_fail_s = (be16(s_axis_tdata[47:32]) != ETHERTYPE_IPV4) ||
                                        (s_axis_tdata[55:48] != IPV4_VER_IHL);
            BEAT_PROTO:   beat_fail_s = (s_axis_tdata[63:56] != IP_PROTO_UDP);
            BEAT_UDP:     beat_fail_s = (be16(s_axis_tdata[47:32]) != UDP_DPORT);
            default:      beat_fail_s = 1'b0;
        endcase
    end

    // Input ready: held low through reset and the first cycle after it
    always_comb begin
        s_ready_s = 1'b0;
        if (ready_en_r) begin
            case (state_r)
                ST_HDR, ST_DROP: s_ready_s = 1'b1;
                ST_PAYLOAD:      s_ready_s = out_free_s;
                ST_FLUSH:        s_ready_s = 1'b0;
                default:         s_ready_s = 1'b0;
            endcase
        end else begin
            s_ready_s = 1'b0;
        end
    end

    assign s_axis_tready = s_ready_s;

    // Parser next state and realigner commands
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        hold_s      = 1'b0;
        push_s      = 1'b0;
        flush_s     = 1'b0;
        hdr_pulse_s = 1'b0;
        case (state_r)
            ST_HDR: begin
                if (hs_s) begin
                    if (s_axis_tlast) begin
                        cnt_s = 3'd0;
                        // Last header beat that ends the frame but still has payload lanes
                        if ((cnt_r == HDR_LAST_BEAT) && tail_has_payload_s) begin
                            hold_s      = 1'b1;
                            hdr_pulse_s = 1'b1;
                            state_s     = ST_FLUSH;
                        end else begin
                            state_s = ST_HDR;
                        end
                    end else if (beat_fail_s) begin
                        cnt_s   = 3'd0;
                        state_s = ST_DROP;
                    end else if (cnt_r == HDR_LAST_BEAT) begin
                        cnt_s       = 3'd0;
                        hold_s      = 1'b1;
                        hdr_pulse_s = 1'b1;
                        state_s     = ST_PAYLOAD;
                    end else begin
                        cnt_s = cnt_r + 3'd1;
                    end
                end else begin
                    cnt_s = cnt_r;
                end
            end
            ST_PAYLOAD: begin
                if (hs_s) begin
                    push_s = 1'b1;
                    if (s_axis_tlast) begin
                        state_s = tail_has_payload_s ? ST_FLUSH : ST_HDR;
                    end else begin
                        state_s = ST_PAYLOAD;
                    end
                end else begin
                    state_s = ST_PAYLOAD;
                end
            end
            ST_FLUSH: begin
                if (out_free_s) begin
                    flush_s = 1'b1;
                    state_s = ST_HDR;
                end else begin
                    state_s = ST_FLUSH;
                end
            end
            ST_DROP: begin
                if (hs_s && s_axis_tlast) begin
                    state_s = ST_HDR;
                end else begin
                    state_s = ST_DROP;
                end
            end
            default: begin
                state_s = ST_HDR;
                cnt_s   = 3'd0;
            end
        endcase
    end

    // Parser state register
    always_ff @(posedge clk156 or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            state_r    <= ST_HDR;
            cnt_r      <= 3'd0;
            ready_en_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            ready_en_r <= 1'b1;
        end
    end

    // Collect header fields from the beats that carry them
    always_ff @(posedge clk156 or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            src_w_r   <= 48'h0;
            saddr_w_r <= 32'h0;
            daddr_w_r <= 32'h0;
            sport_w_r <= 16'h0;
            ulen_w_r  <= 16'h0;
        end else if (hs_s && (state_r == ST_HDR)) begin
            case (cnt_r)
                BEAT_DST_MAC: src_w_r[47:32] <= be16(s_axis_tdata[63:48]);
                BEAT_ETYPE:   src_w_r[31:0]  <= be32(s_axis_tdata[31:0]);
                BEAT_SADDR: begin
                    saddr_w_r        <= be32(s_axis_tdata[47:16]);
                    daddr_w_r[31:16] <= be16(s_axis_tdata[63:48]);
                end
                BEAT_UDP: begin
                    daddr_w_r[15:0] <= be16(s_axis_tdata[15:0]);
                    sport_w_r       <= be16(s_axis_tdata[31:16]);
                    ulen_w_r        <= be16(s_axis_tdata[63:48]);
                end
                default: begin
                end
            endcase
        end
    end

    // Publish header fields together with the hdr_valid pulse
    always_ff @(posedge clk156 or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            hdr_valid_r <= 1'b0;
            eth_src_r   <= 48'h0;
            ip_saddr_r  <= 32'h0;
            ip_daddr_r  <= 32'h0;
            udp_sport_r <= 16'h0;
            udp_len_r   <= 16'h0;
        end else begin
            hdr_valid_r <= hdr_pulse_s;
            if (hdr_pulse_s) begin
                eth_src_r   <= src_w_r;
                ip_saddr_r  <= saddr_w_r;
                ip_daddr_r  <= daddr_w_r;
                udp_sport_r <= sport_w_r;
                udp_len_r   <= ulen_w_r;
            end
        end
    end

    assign hdr_valid = hdr_valid_r;
    assign eth_src   = eth_src_r;
    assign ip_saddr  = ip_saddr_r;
    assign ip_daddr  = ip_daddr_r;
    assign udp_sport = udp_sport_r;
    assign udp_len   = udp_len_r;

    eth_realign u_realign (
        .clk      (clk156),
        .rst_n    (eth_rst_n),
        .hold_en  (hold_s),
        .push_en  (push_s),
        .flush_en (flush_s),
        .in_data  (s_axis_tdata),
        .in_keep  (s_axis_tkeep),
        .in_last  (s_axis_tlast),
        .in_user  (s_axis_tuser),
        .m_tready (m_axis_tready),
        .out_free (out_free_s),
        .m_tvalid (m_axis_tvalid),
        .m_tdata  (m_axis_tdata),
        .m_tkeep  (m_axis_tkeep),
        .m_tlast  (m_axis_tlast),
        .m_tuser  (m_axis_tuser)
    );

`ifdef ETH_DECAP_STATS_EN
    logic [31:0] accept_cnt_r, drop_cnt_r;
    logic        frame_end_s, frame_ok_s;

    // A frame is kept if it closes in PAYLOAD or closes its header straight into FLUSH
    assign frame_end_s = hs_s && s_axis_tlast;
    assign frame_ok_s  = frame_end_s && ((state_r == ST_PAYLOAD) || (state_s == ST_FLUSH));

    // Per-frame tallies at each frame's closing handshake, free-running wrap
    always_ff @(posedge clk156 or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            accept_cnt_r <= 32'h0;
            drop_cnt_r   <= 32'h0;
        end else if (frame_ok_s) begin
            accept_cnt_r <= accept_cnt_r + 32'd1;
        end else if (frame_end_s) begin
            drop_cnt_r <= drop_cnt_r + 32'd1;
        end
    end

    assign rx_accept_cnt = accept_cnt_r;
    assign rx_drop_cnt   = drop_cnt_r;
`endif

endmodule

// File: tb/tb_eth_decap.sv
// ---------------------------------------------------------------------------
// tb_eth_decap -- directed bench for eth_decap (default build).
// Frames are built byte by byte, sent on s_axis, and the payload collected
// from m_axis is compared against the bytes that were put in.
// ---------------------------------------------------------------------------
module tb_eth_decap;

    localparam logic [47:0] MY_MAC   = 48'h00_11_22_33_44_55;
    localparam logic [15:0] MY_PORT  = 16'h3776;
    localparam logic [47:0] SRC_MAC  = 48'h02_AA_BB_CC_DD_EE;
    localparam logic [31:0] SRC_IP   = 32'hC0A8_010A;
    localparam logic [31:0] DST_IP   = 32'hC0A8_0114;
    localparam logic [15:0] SRC_PORT = 16'hABCD;

    logic        clk156 = 1'b0;
    logic        eth_rst_n;
    logic        s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
    logic [63:0] s_axis_tdata;
    logic [7:0]  s_axis_tkeep;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        hdr_valid;
    logic [47:0] eth_src;
    logic [31:0] ip_saddr, ip_daddr;
    logic [15:0] udp_sport, udp_len;

    int          n_total = 0;
    int          n_bad   = 0;
    bit          rand_mode = 1'b0;
    logic [7:0]  frm [0:255];

    // monitor-owned records
    logic [7:0]  ob_q [$];
    logic [7:0]  ok_q [$];
    logic        ol_q [$];
    logic        ou_q [$];
    int          hdr_cnt = 0;
    bit          saw_stall = 1'b0;

    always #5 clk156 = ~clk156;

    eth_decap dut (
        .clk156        (clk156),
        .eth_rst_n     (eth_rst_n),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .hdr_valid     (hdr_valid),
        .eth_src       (eth_src),
        .ip_saddr      (ip_saddr),
        .ip_daddr      (ip_daddr),
        .udp_sport     (udp_sport),
        .udp_len       (udp_len)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output / handshake monitor, sampled away from the rising edge
    always @(negedge clk156) begin
        if (eth_rst_n) begin
            if (hdr_valid) hdr_cnt++;
            if (s_axis_tvalid && !s_axis_tready) saw_stall = 1'b1;
            if (m_axis_tvalid && m_axis_tready) begin
                for (int l = 0; l < 8; l++) begin
                    if (m_axis_tkeep[l]) ob_q.push_back(m_axis_tdata[8*l +: 8]);
                end
                ok_q.push_back(m_axis_tkeep);
                ol_q.push_back(m_axis_tlast);
                ou_q.push_back(m_axis_tuser);
            end
        end
    end

    // Downstream ready: always 1, or a coin flip every cycle in random mode
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk156);
            #1;
            m_axis_tready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic build_frame(input logic [47:0] dmac, input logic [15:0] dport,
                               input int plen, input logic [7:0] pbase);
        logic [15:0] ulen;
        ulen = 16'(8 + plen);
        for (int i = 0; i < 256; i++) frm[i] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            frm[i]     = 8'(dmac >> (8 * (5 - i)));
            frm[6 + i] = 8'(SRC_MAC >> (8 * (5 - i)));
        end
        frm[12] = 8'h08; frm[13] = 8'h00; frm[14] = 8'h45;
        frm[22] = 8'h40; frm[23] = 8'd17;
        for (int i = 0; i < 4; i++) begin
            frm[26 + i] = 8'(SRC_IP >> (8 * (3 - i)));
            frm[30 + i] = 8'(DST_IP >> (8 * (3 - i)));
        end
        frm[34] = SRC_PORT[15:8]; frm[35] = SRC_PORT[7:0];
        frm[36] = dport[15:8];    frm[37] = dport[7:0];
        frm[38] = ulen[15:8];     frm[39] = ulen[7:0];
        for (int i = 0; i < plen; i++) frm[42 + i] = pbase + 8'(i);
    endtask

    // Send the first flen bytes of frm; stop before beat abort_beat (-1 = never)
    task automatic send_frame(input int flen, input int abort_beat);
        int nb;
        int w;
        bit rdy;
        nb = (flen + 7) / 8;
        for (int b = 0; (b < nb) && (b != abort_beat); b++) begin
            for (int l = 0; l < 8; l++) begin
                if (8 * b + l < flen) begin
                    s_axis_tdata[8*l +: 8] = frm[8 * b + l];
                    s_axis_tkeep[l]        = 1'b1;
                end else begin
                    s_axis_tdata[8*l +: 8] = 8'h00;
                    s_axis_tkeep[l]        = 1'b0;
                end
            end
            s_axis_tlast  = (b == nb - 1);
            s_axis_tuser  = (b == nb - 1);
            s_axis_tvalid = 1'b1;
            w = 0;
            do begin
                @(negedge clk156);
                rdy = s_axis_tready;
                @(posedge clk156);
                #1;
                w++;
            end while (!rdy && w < 2000);
            if (!rdy) chk("s_ready_wait", 64'(rdy), 64'd1);
        end
        if (abort_beat < 0) begin
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
            s_axis_tuser  = 1'b0;
        end
    endtask

    task automatic drain(input int want, input int base);
        int w;
        w = 0;
        repeat (4) @(posedge clk156);
        while ((((ob_q.size() - base) < want) || m_axis_tvalid) && (w < 400)) begin
            @(posedge clk156);
            w++;
        end
        if (w >= 400) chk("drain_timeout", 64'(w), 64'd0);
        @(posedge clk156);
        #1;
    endtask

    task automatic run_frame(input string tag, input logic [47:0] dmac, input logic [15:0] dport,
                             input int plen, input logic [7:0] pbase, input int acc,
                             input int exp_beats, input logic [7:0] exp_lkeep, input bit rnd);
        int bb, kb, hb, mism, nl, nbytes;
        bb = ob_q.size(); kb = ok_q.size(); hb = hdr_cnt; mism = 0; nl = 0;
        build_frame(dmac, dport, plen, pbase);
        rand_mode = rnd;
        send_frame(42 + plen, -1);
        drain((acc != 0) ? plen : 0, bb);
        rand_mode = 1'b0;
        repeat (2) @(posedge clk156);
        #1;
        nbytes = ob_q.size() - bb;
        chk($sformatf("%s.hdr_pulses", tag), 64'(hdr_cnt - hb), 64'(acc));
        chk($sformatf("%s.nbytes", tag), 64'(nbytes), 64'((acc != 0) ? plen : 0));
        for (int i = 0; i < nbytes && i < plen; i++) begin
            if (ob_q[bb + i] !== pbase + 8'(i)) mism++;
        end
        chk($sformatf("%s.data", tag), 64'(mism), 64'd0);
        if (acc != 0) begin
            chk($sformatf("%s.beats", tag), 64'(ok_q.size() - kb), 64'(exp_beats));
            for (int j = kb; j < ol_q.size(); j++) nl += int'(ol_q[j]);
            chk($sformatf("%s.tlast_cnt", tag), 64'(nl), 64'd1);
            if (ok_q.size() > kb) begin
                chk($sformatf("%s.last_keep", tag), 64'(ok_q[ok_q.size() - 1]), 64'(exp_lkeep));
                chk($sformatf("%s.last_tlast", tag), 64'(ol_q[ol_q.size() - 1]), 64'd1);
                chk($sformatf("%s.last_tuser", tag), 64'(ou_q[ou_q.size() - 1]), 64'd1);
            end
            chk($sformatf("%s.eth_src", tag), 64'(eth_src), 64'(SRC_MAC));
            chk($sformatf("%s.ip_saddr", tag), 64'(ip_saddr), 64'(SRC_IP));
            chk($sformatf("%s.ip_daddr", tag), 64'(ip_daddr), 64'(DST_IP));
            chk($sformatf("%s.udp_sport", tag), 64'(udp_sport), 64'(SRC_PORT));
            chk($sformatf("%s.udp_len", tag), 64'(udp_len), 64'(8 + plen));
        end
    endtask

    initial begin
        int bb, hb;
        eth_rst_n     = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 64'h0;
        s_axis_tkeep  = 8'h0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;

        // reset state
        repeat (2) @(negedge clk156);
        chk("rst.m_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst.m_tdata", m_axis_tdata, 64'd0);
        chk("rst.s_tready", 64'(s_axis_tready), 64'd0);
        chk("rst.hdr_valid", 64'(hdr_valid), 64'd0);
        chk("rst.eth_src", 64'(eth_src), 64'd0);
        @(posedge clk156); #1;
        eth_rst_n = 1'b1;
        repeat (2) @(posedge clk156);
        #1;

        // main function and boundaries: (tag, dmac, dport, plen, pbase, acc, beats, last keep, random)
        run_frame("p50",    MY_MAC, MY_PORT, 50, 8'h00, 1, 7, 8'h03, 1'b0);
        run_frame("dport",  MY_MAC, 16'h1234, 50, 8'h00, 0, 0, 8'h00, 1'b0);
        run_frame("dmac",   48'h00_11_22_33_44_56, MY_PORT, 20, 8'h00, 0, 0, 8'h00, 1'b0);
        run_frame("bcast",  48'hFF_FF_FF_FF_FF_FF, MY_PORT, 16, 8'h40, 1, 2, 8'hFF, 1'b0);
        run_frame("p6",     MY_MAC, MY_PORT, 6,  8'h80, 1, 1, 8'h3F, 1'b0);
        run_frame("p7",     MY_MAC, MY_PORT, 7,  8'h90, 1, 1, 8'h7F, 1'b0);
        run_frame("p15",    MY_MAC, MY_PORT, 15, 8'hA0, 1, 2, 8'h7F, 1'b0);
        run_frame("p0",     MY_MAC, MY_PORT, 0,  8'h00, 0, 0, 8'h00, 1'b0);

        // runt ending on beat 3, then a clean frame
        bb = ob_q.size(); hb = hdr_cnt;
        build_frame(MY_MAC, MY_PORT, 20, 8'h00);
        send_frame(30, -1);
        repeat (10) @(posedge clk156);
        #1;
        chk("runt.hdr_pulses", 64'(hdr_cnt - hb), 64'd0);
        chk("runt.nbytes", 64'(ob_q.size() - bb), 64'd0);
        run_frame("after_runt", MY_MAC, MY_PORT, 9, 8'h30, 1, 2, 8'h01, 1'b0);

        // 50% downstream back-pressure
        run_frame("p50_rnd", MY_MAC, MY_PORT, 50, 8'h00, 1, 7, 8'h03, 1'b1);
        chk("rnd.s_ready_stalled", 64'(saw_stall), 64'd1);

        // reset during payload beat 3 (input beat 8)
        build_frame(MY_MAC, MY_PORT, 50, 8'h10);
        send_frame(92, 8);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        eth_rst_n     = 1'b0;
        @(negedge clk156);
        chk("midrst.m_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("midrst.m_tdata", m_axis_tdata, 64'd0);
        chk("midrst.m_tkeep", 64'(m_axis_tkeep), 64'd0);
        chk("midrst.m_tlast", 64'(m_axis_tlast), 64'd0);
        chk("midrst.hdr_valid", 64'(hdr_valid), 64'd0);
        chk("midrst.s_tready", 64'(s_axis_tready), 64'd0);
        chk("midrst.eth_src", 64'(eth_src), 64'd0);
        chk("midrst.udp_len", 64'(udp_len), 64'd0);
        @(posedge clk156); #1;
        eth_rst_n = 1'b1;
        repeat (2) @(posedge clk156);
        #1;
        run_frame("after_rst", MY_MAC, MY_PORT, 23, 8'h20, 1, 3, 8'h7F, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
